// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the single-issue CSE-BUBBLE datapath:
// sequences fetch/decode/execute/memory/writeback, owns PC, IR and retirement.
module multicycle_sequencer #(
  parameter int              PC_W     = 32,
  parameter int              CNT_W    = 32,
  parameter int              TIMEOUT  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [PC_W-1:0]  pc,
  output logic [31:0]      instr,
  input  logic             branch_cond,
  input  logic [PC_W-1:0]  jump_target,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             busy,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  function automatic logic writes_rf(input logic [5:0] op);
    return !(op >= 6'd13 && op <= 6'd19);
  endfunction

  function automatic logic is_taken(input logic [5:0] op, input logic cond);
    return ((op >= 6'd14 && op <= 6'd19) && cond) || (op >= 6'd20 && op <= 6'd22);
  endfunction

  function automatic logic is_illegal(input logic [5:0] op);
    return (op >= 6'd25 && op <= 6'd62);
  endfunction

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               bus_err_q, bus_err_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               br_q;
  logic [PC_W-1:0]    tgt_q;
  logic [5:0]         opcode;
  logic               wait_expired;

  assign opcode       = instr_q[31:26];
  assign wait_expired = (wait_q == WAIT_W'(TIMEOUT - 1));

  // Wait counter is zero in every state outside FETCH/MEM, so it is clear on entry.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    bus_err_d = bus_err_q;
    wait_d    = '0;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (opcode == 6'd63 || is_illegal(opcode)) state_d = S_HALT;
        else                                         state_d = S_EXEC;
      end
      S_EXEC:   state_d = (opcode == 6'd12 || opcode == 6'd13) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (wait_expired) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        pc_d      = is_taken(opcode, br_q) ? tgt_q : pc_q + 1'b1;
        retired_d = retired_q + 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
      bus_err_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      bus_err_q <= bus_err_d;
      wait_q    <= wait_d;
    end
  end

  // Branch decision inputs are only guaranteed valid in EXEC; hold them for WB.
  always_ff @(posedge clk) begin
    if (state_q == S_EXEC) begin
      br_q  <= branch_cond;
      tgt_q <= jump_target;
    end
  end

  assign imem_req = (state_q == S_FETCH);
  assign dmem_req = (state_q == S_MEM);
  assign dmem_we  = (state_q == S_MEM) && (opcode == 6'd13);
  assign rf_we    = (state_q == S_WB) && writes_rf(opcode);
  assign busy     = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted   = (state_q == S_HALT);
  assign bus_err  = bus_err_q;
  assign pc       = pc_q;
  assign instr    = instr_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: directed programs, memory responder,
// and a monitor that checks each retirement / halt event against queued expectations.
module tb_multicycle_sequencer;

  logic        clk, rst, start;
  logic        imem_req, imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc, instr, jump_target, retired;
  logic        branch_cond, dmem_req, dmem_we, dmem_ack, rf_we, busy, halted, bus_err;

  multicycle_sequencer #(
    .PC_W(32), .CNT_W(32), .TIMEOUT(4), .RESET_PC(32'd8)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .instr(instr), .branch_cond(branch_cond), .jump_target(jump_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .busy(busy), .halted(halted), .bus_err(bus_err), .retired(retired)
  );

  typedef struct {
    bit          is_halt;
    logic [31:0] pc;
    logic [31:0] ret;
    logic [31:0] be;
    int          rf;
    int          dm;
    int          dwe;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] prog[256];
  bit          bc[256];
  logic [31:0] jt[256];
  int          dw[256];
  int          imem_wait = 0;

  int          lat_cnt, rf_cnt, dm_cnt, dwe_cnt;
  logic [31:0] prev_ret;
  logic        prev_halt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mk(input logic [5:0] op);
    return {op, 26'h2A5A5A5};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ret(input logic [31:0] p, input logic [31:0] r, input int rf,
                          input int dm, input int dwe, input int lat);
    exp_t e;
    e.is_halt = 1'b0; e.pc = p; e.ret = r; e.be = 32'd0;
    e.rf = rf; e.dm = dm; e.dwe = dwe; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic push_halt(input logic [31:0] p, input logic [31:0] r, input logic [31:0] be,
                           input int dm, input int lat);
    exp_t e;
    e.is_halt = 1'b1; e.pc = p; e.ret = r; e.be = be;
    e.rf = 0; e.dm = dm; e.dwe = 0; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input bit halt_ev);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: got event halt=%0d at pc=0x%0h, expected no event", halt_ev, pc);
      return;
    end
    e = sb.pop_front();
    check("event_kind",      32'(halt_ev), 32'(e.is_halt));
    check("pc",              pc, e.pc);
    check("retired",         retired, e.ret);
    check("bus_err",         32'(bus_err), e.be);
    check("rf_we_cycles",    32'(rf_cnt), 32'(e.rf));
    check("dmem_req_cycles", 32'(dm_cnt), 32'(e.dm));
    check("dmem_we_cycles",  32'(dwe_cnt), 32'(e.dwe));
    check("latency",         32'(lat_cnt), 32'(e.lat));
  endtask

  // Monitor: an event is a change of retired or a rising halted.
  initial begin
    lat_cnt = 0; rf_cnt = 0; dm_cnt = 0; dwe_cnt = 0;
    prev_ret = '0; prev_halt = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lat_cnt = 0; rf_cnt = 0; dm_cnt = 0; dwe_cnt = 0;
        prev_ret = retired; prev_halt = halted;
      end else begin
        if (retired !== prev_ret || (halted && !prev_halt)) begin
          pop_cmp(halted && !prev_halt);
          lat_cnt = 0; rf_cnt = 0; dm_cnt = 0; dwe_cnt = 0;
        end
        prev_ret  = retired;
        prev_halt = halted;
        if (busy)                lat_cnt++;
        if (rf_we)               rf_cnt++;
        if (dmem_req)            dm_cnt++;
        if (dmem_req && dmem_we) dwe_cnt++;
      end
    end
  end

  // Memory responder: acks after a programmable number of wait cycles.
  initial begin
    int icnt, dcnt;
    icnt = 0; dcnt = 0;
    imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0;
    branch_cond = 1'b0; jump_target = '0;
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (rst) begin
        icnt = 0; dcnt = 0;
      end else begin
        if (imem_req) begin
          if (icnt == imem_wait) begin
            imem_ack    = 1'b1;
            imem_rdata  = prog[pc[7:0]];
            branch_cond = bc[pc[7:0]];
            jump_target = jt[pc[7:0]];
            icnt = 0;
          end else icnt++;
        end else icnt = 0;
        if (dmem_req) begin
          if (dcnt == dw[pc[7:0]]) begin
            dmem_ack = 1'b1;
            dcnt = 0;
          end else dcnt++;
        end else dcnt = 0;
      end
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      prog[i] = mk(6'd63); bc[i] = 1'b0; jt[i] = '0; dw[i] = 0;
    end
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (chk) begin
      check("rst_pc",       pc, 32'd8);
      check("rst_instr",    instr, 32'd0);
      check("rst_retired",  retired, 32'd0);
      check("rst_busy",     32'(busy), 32'd0);
      check("rst_halted",   32'(halted), 32'd0);
      check("rst_bus_err",  32'(bus_err), 32'd0);
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_dmem_req", 32'(dmem_req), 32'd0);
      check("rst_rf_we",    32'(rf_we), 32'd0);
    end
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_to_halt(input string name, input int budget);
    int n;
    n = 0;
    pulse_start();
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({name, "_halted"}, 32'(halted), 32'd1);
    check({name, "_sb_drained"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0;
    clear_prog();

    // ALU sequence then opcode 63
    do_reset(1'b1);
    prog[8] = mk(6'd0); prog[9] = mk(6'd0); prog[10] = mk(6'd0);
    push_ret(32'd9, 32'd1, 1, 0, 0, 4);
    push_ret(32'd10, 32'd2, 1, 0, 0, 4);
    push_ret(32'd11, 32'd3, 1, 0, 0, 4);
    push_halt(32'd11, 32'd3, 32'd0, 0, 2);
    run_to_halt("alu", 200);

    // Store with 2 wait states, zero-wait load, illegal opcode 30
    clear_prog();
    do_reset(1'b0);
    prog[8] = mk(6'd13); dw[8] = 2;
    prog[9] = mk(6'd12);
    prog[10] = mk(6'd30);
    push_ret(32'd9, 32'd1, 0, 3, 3, 7);
    push_ret(32'd10, 32'd2, 1, 1, 0, 5);
    push_halt(32'd10, 32'd2, 32'd0, 0, 2);
    run_to_halt("mem", 200);

    // Branches, jumps, opcode-range boundaries
    clear_prog();
    do_reset(1'b0);
    prog[8]    = mk(6'd14); bc[8]    = 1'b1; jt[8]    = 32'h40;
    prog[8'h40] = mk(6'd14); bc[8'h40] = 1'b0; jt[8'h40] = 32'h10;
    prog[8'h41] = mk(6'd20); bc[8'h41] = 1'b0; jt[8'h41] = 32'h80;
    prog[8'h80] = mk(6'd19); bc[8'h80] = 1'b1; jt[8'h80] = 32'h5;
    prog[5]    = mk(6'd17); bc[5]    = 1'b0; jt[5]    = 32'h33;
    prog[6]    = mk(6'd22); bc[6]    = 1'b0; jt[6]    = 32'h20;
    prog[8'h20] = mk(6'd24);
    prog[8'h21] = mk(6'd25);
    push_ret(32'h40, 32'd1, 0, 0, 0, 4);
    push_ret(32'h41, 32'd2, 0, 0, 0, 4);
    push_ret(32'h80, 32'd3, 1, 0, 0, 4);
    push_ret(32'h05, 32'd4, 0, 0, 0, 4);
    push_ret(32'h06, 32'd5, 0, 0, 0, 4);
    push_ret(32'h20, 32'd6, 1, 0, 0, 4);
    push_ret(32'h21, 32'd7, 1, 0, 0, 4);
    push_halt(32'h21, 32'd7, 32'd0, 0, 2);
    run_to_halt("branch", 300);

    // Instruction fetch timeout; HALT must ignore start
    clear_prog();
    do_reset(1'b0);
    imem_wait = 100;
    push_halt(32'd8, 32'd0, 32'd1, 0, 4);
    run_to_halt("ifetch_timeout", 100);
    check("timeout_imem_req_low", 32'(imem_req), 32'd0);
    pulse_start();
    @(negedge clk);
    check("halt_ignores_start_halted", 32'(halted), 32'd1);
    check("halt_ignores_start_busy",   32'(busy), 32'd0);
    check("halt_ignores_start_req",    32'(imem_req), 32'd0);
    check("bus_err_sticky",            32'(bus_err), 32'd1);
    imem_wait = 0;

    // Data access timeout (also checks reset clears bus_err)
    clear_prog();
    do_reset(1'b1);
    prog[8] = mk(6'd12); dw[8] = 100;
    push_halt(32'd8, 32'd0, 32'd1, 4, 7);
    run_to_halt("dmem_timeout", 100);

    // Reset during an outstanding load
    clear_prog();
    do_reset(1'b0);
    prog[8] = mk(6'd0);
    prog[9] = mk(6'd12); dw[9] = 100;
    push_ret(32'd9, 32'd1, 1, 0, 0, 4);
    pulse_start();
    n = 0;
    while (!dmem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midmem_dmem_req_seen", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midmem_dmem_req", 32'(dmem_req), 32'd0);
    check("midmem_busy",     32'(busy), 32'd0);
    check("midmem_halted",   32'(halted), 32'd0);
    check("midmem_pc",       pc, 32'd8);
    check("midmem_instr",    instr, 32'd0);
    check("midmem_retired",  retired, 32'd0);
    check("midmem_rf_we",    32'(rf_we), 32'd0);
    check("midmem_sb_drained", 32'(sb.size()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midmem_idle_no_req", 32'(imem_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
